// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction-fetch sequencer.
package fetch_pkg;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {FETCH = 2'd0, HALTED = 2'd1, DONE = 2'd2} fetch_state_t;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: ROM, decode handshake and control signals of the fetch sequencer.
interface fetch_if #(parameter int N = 32);
   logic [N-1:0] imem_pc, imem_instr, out_instr, out_pc, redirect_pc;
   logic out_valid, out_ready, redirect_valid, halt;
   logic [1:0] fetch_state;
   modport master (
      output imem_pc, out_valid, out_instr, out_pc, fetch_state,
      input imem_instr, out_ready, redirect_valid, redirect_pc, halt
   );
   modport slave (
      input imem_pc, out_valid, out_instr, out_pc, fetch_state,
      output imem_instr, out_ready, redirect_valid, redirect_pc, halt
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order prefetch queue with flush; push and pop may coincide when full.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter type T = fetch_entry_t
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic push,
   input  logic pop,
   input  T     din,
   output T     dout,
   output logic full,
   output logic empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   T mem [DEPTH];
   logic [AW-1:0] rd, wr;
   always_ff @(posedge clk) if (push) mem[wr] <= din;
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (push) wr <= wr + 1'b1;
         if (pop) rd <= rd + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   assign dout  = mem[rd];
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches words from a combinational ROM into a
// prefetch FIFO and hands them to decode; handles redirect, halt and end-of-program.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int N = XLEN,
   parameter int INS = 1000,
   parameter int DEPTH = 4,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input logic clk,
   input logic rst,
   fetch_if.master bus
);
   localparam logic [1:0] S_FETCH  = 2'(FETCH);
   localparam logic [1:0] S_HALTED = 2'(HALTED);
   localparam logic [1:0] S_DONE   = 2'(DONE);
   localparam logic [N-1:0] LAST   = N'(INS - 1);
   localparam logic [N-1:0] END_PC = N'(INS);
   logic [N-1:0] pc;
   logic [1:0] state, state_n;
   logic push, pop, full, empty;
   logic [$clog2(DEPTH):0] count;
   fetch_entry_t entry, head;
   // A redirect discards the same-cycle pop; a full FIFO still accepts when it pops.
   assign pop   = bus.out_ready && count != '0 && !bus.redirect_valid;
   assign push  = state == S_FETCH && !bus.halt && !bus.redirect_valid && (!full || pop);
   assign entry = '{pc: pc, instr: bus.imem_instr};
   always_comb begin
      state_n = bus.redirect_valid ?
                  (bus.redirect_pc >= END_PC ? S_DONE :
                   (state == S_HALTED || bus.halt) ? S_HALTED : S_FETCH) :
                state == S_FETCH  ? (bus.halt ? S_HALTED : (push && pc == LAST) ? S_DONE : S_FETCH) :
                state == S_HALTED ? (bus.halt ? S_HALTED : S_FETCH) : S_DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC;
         state <= RESET_PC >= END_PC ? S_DONE : S_FETCH;
      end else begin
         pc    <= bus.redirect_valid ? bus.redirect_pc : push ? pc + N'(1) : pc;
         state <= state_n;
      end
   end
   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
      .clk(clk), .rst(rst), .flush(bus.redirect_valid), .push(push), .pop(pop),
      .din(entry), .dout(head), .full(full), .empty(empty), .count(count)
   );
   assign bus.imem_pc     = pc;
   assign bus.out_valid   = !empty;
   assign bus.out_instr   = head.instr;
   assign bus.out_pc      = head.pc;
   assign bus.fetch_state = state;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table on a 1000-word ROM plus a hand-written
// end-of-program sequence on an 8-word ROM; ROM word k holds k+100.
module tb_fetch_sequencer;
   logic clk = 0;
   logic rst_a, rst_b;
   int errors = 0, checks = 0;
   fetch_if #(.N(32)) fa ();
   fetch_if #(.N(32)) fb ();
   assign fa.imem_instr = fa.imem_pc + 32'd100;
   assign fb.imem_instr = fb.imem_pc + 32'd100;
   fetch_sequencer #(.N(32), .INS(1000), .DEPTH(4), .RESET_PC(32'd0)) ua (.clk(clk), .rst(rst_a), .bus(fa));
   fetch_sequencer #(.N(32), .INS(8), .DEPTH(4), .RESET_PC(32'd0)) ub (.clk(clk), .rst(rst_b), .bus(fb));
   always #5 clk = ~clk;

   typedef struct {
      logic rst, rdy, rdv, hlt, ev;
      logic [31:0] rpc, epc, eimem;
      logic [1:0] est;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic r, rd, rv, input int rp, input logic h, ev,
                      input int ep, ei, es);
      vec_t v;
      v.rst = r; v.rdy = rd; v.rdv = rv; v.rpc = rp; v.hlt = h;
      v.ev = ev; v.epc = ep; v.eimem = ei; v.est = 2'(es);
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   initial begin
      rst_a = 1; rst_b = 1;
      fa.out_ready = 0; fa.redirect_valid = 0; fa.redirect_pc = 0; fa.halt = 0;
      fb.out_ready = 1; fb.redirect_valid = 0; fb.redirect_pc = 0; fb.halt = 0;
      // rst rdy rdv rpc hlt | ev epc imem state
      add(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) add(0, 0, 0, 0, 0, 1, 0, k, 0);
      for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 0, 1, 0, 4, 0);
      for (int k = 1; k <= 5; k++) add(0, 1, 0, 0, 0, 1, k, k + 4, 0);
      add(0, 1, 0, 0, 1, 1, 6, 9, 1);
      add(0, 1, 0, 0, 1, 1, 7, 9, 1);
      add(0, 1, 0, 0, 1, 1, 8, 9, 1);
      add(0, 1, 0, 0, 0, 0, 0, 9, 0);
      add(0, 1, 0, 0, 0, 1, 9, 10, 0);
      add(0, 0, 0, 0, 0, 1, 9, 11, 0);
      add(0, 0, 0, 0, 0, 1, 9, 12, 0);
      add(0, 1, 1, 50, 0, 0, 0, 50, 0);
      add(0, 1, 0, 0, 0, 1, 50, 51, 0);
      add(0, 1, 0, 0, 0, 1, 51, 52, 0);
      add(0, 0, 0, 0, 0, 1, 51, 53, 0);
      add(0, 0, 0, 0, 0, 1, 51, 54, 0);
      add(0, 0, 0, 0, 0, 1, 51, 55, 0);
      add(1, 0, 1, 70, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 1, 0, 1, 0);
      add(0, 1, 1, 1000, 0, 0, 0, 1000, 2);
      add(0, 1, 0, 0, 0, 0, 0, 1000, 2);
      add(0, 1, 1, 5, 1, 0, 0, 5, 1);
      add(0, 1, 0, 0, 0, 0, 0, 5, 0);
      add(0, 1, 0, 0, 0, 1, 5, 6, 0);
      add(0, 1, 0, 0, 0, 1, 6, 7, 0);
      foreach (vecs[i]) begin
         rst_a = vecs[i].rst; fa.out_ready = vecs[i].rdy; fa.redirect_valid = vecs[i].rdv;
         fa.redirect_pc = vecs[i].rpc; fa.halt = vecs[i].hlt;
         @(posedge clk); #1;
         chk($sformatf("v%0d valid", i), 32'(fa.out_valid), 32'(vecs[i].ev));
         chk($sformatf("v%0d imem_pc", i), fa.imem_pc, vecs[i].eimem);
         chk($sformatf("v%0d state", i), 32'(fa.fetch_state), 32'(vecs[i].est));
         if (vecs[i].ev) begin
            chk($sformatf("v%0d out_pc", i), fa.out_pc, vecs[i].epc);
            chk($sformatf("v%0d out_instr", i), fa.out_instr, vecs[i].epc + 32'd100);
         end
      end
      rst_a = 1;
      // 8-word program: deliver all words, reach DONE, then restart by redirect
      chk("b reset valid", 32'(fb.out_valid), 32'd0);
      chk("b reset imem_pc", fb.imem_pc, 32'd0);
      chk("b reset state", 32'(fb.fetch_state), 32'd0);
      rst_b = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         chk($sformatf("b deliver%0d valid", k), 32'(fb.out_valid), 32'd1);
         chk($sformatf("b deliver%0d pc", k), fb.out_pc, 32'(k));
         chk($sformatf("b deliver%0d instr", k), fb.out_instr, 32'(k + 100));
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("b done%0d valid", k), 32'(fb.out_valid), 32'd0);
         chk($sformatf("b done%0d imem_pc", k), fb.imem_pc, 32'd8);
         chk($sformatf("b done%0d state", k), 32'(fb.fetch_state), 32'd2);
      end
      fb.redirect_valid = 1; fb.redirect_pc = 2;
      @(posedge clk); #1;
      chk("b redir valid", 32'(fb.out_valid), 32'd0);
      chk("b redir imem_pc", fb.imem_pc, 32'd2);
      chk("b redir state", 32'(fb.fetch_state), 32'd0);
      fb.redirect_valid = 0;
      for (int k = 2; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("b restart%0d valid", k), 32'(fb.out_valid), 32'd1);
         chk($sformatf("b restart%0d pc", k), fb.out_pc, 32'(k));
         chk($sformatf("b restart%0d instr", k), fb.out_instr, 32'(k + 100));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller placed between the core's decode stage and the word-indexed instruction ROM. It owns the program counter, drives the ROM address every cycle, and captures each returned word with its PC into a small prefetch FIFO. It hands instructions to decode over a valid/ready handshake and handles redirects (branches or jumps), halts and end-of-program.

## Interface
- N, 32, instruction and PC width
- INS, 1000, number of ROM words; legal PCs are 0..INS-1
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 0, PC loaded at reset
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_pc  out  N  ROM word index; ROM read is combinational, word returns the same cycle
- imem_instr  in  N  ROM data for imem_pc
- out_valid  out  1  FIFO head holds an instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  N  head instruction word
- out_pc  out  N  PC of head instruction
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  N  new fetch PC
- halt  in  1  suspend fetching (level)
- fetch_state  out  2  current state, encoding from package

## Operation
- States: FETCH, HALTED, DONE.
- FETCH: push {imem_pc, imem_instr} and increment the PC when the FIFO is not full or a pop occurs in the same cycle. Otherwise hold the PC with no push.
- The PC increments by 1 because the ROM is word-indexed. After a push from PC = INS-1, the block enters DONE with the PC = INS. An address ≥ INS is never pushed.
- HALTED: entered from FETCH when halt=1, left when halt=0. No pushes occur; the FIFO continues to drain.
- DONE: no pushes; the FIFO drains. Only redirect or rst exits this state.
- Redirect, in any state: the FIFO is emptied, the same-cycle pop is discarded, there is no push, and PC <= redirect_pc.
  - Next state is FETCH from FETCH or DONE, HALTED from HALTED (or if halt=1).
  - If redirect_pc ≥ INS, the next state is DONE.
- Priority: rst > redirect > halt > normal fetch.
- Pop happens when out_valid && out_ready. Push and pop may occur in the same cycle, including when the FIFO is full; the count is then unchanged.
- FIFO order is strictly in order. The count ranges 0..DEPTH and the read and write pointers wrap modulo DEPTH.
- out_instr and out_pc are don't-care when out_valid=0.

## Timing
- Reset values: PC = RESET_PC, state = FETCH (DONE if RESET_PC ≥ INS), FIFO empty, out_valid = 0, imem_pc = RESET_PC.
- imem_pc equals the registered PC, with no combinational path from out_ready or redirect.
- Fetch-to-output latency is 1 cycle. A word pushed at edge t is visible with out_valid=1 after that edge.
- With out_ready held at 1, throughput is 1 instruction per cycle.
- Redirect asserted in cycle t:
  - From edge t onward out_valid=0 and imem_pc=redirect_pc.
  - The first redirected instruction is valid after edge t+1.
- halt asserted in cycle t: no push at edge t. halt deasserted in cycle t: the first push occurs at edge t+1.
- rst asserted mid-stream discards FIFO contents at that edge.

## Structure
- Package fetch_pkg holds the fetch_state_t enum (FETCH=0, HALTED=1, DONE=2) and a fetch_entry_t struct {pc, instr}.
- Sub-module fetch_fifo is parameterized by DEPTH and fetch_entry_t. It provides a push/pop/flush interface with full, empty and count outputs.
- The top-level fetch_sequencer holds the PC register, the state machine and the push/pop arbitration.

## Test plan
- Reset with out_ready=1 and the ROM holding word k = k+100:
  - out_valid rises after edge 1.
  - out_pc reads 0,1,2,… and out_instr reads 100,101,… on consecutive cycles.
- out_ready=0 for 10 cycles:
  - Exactly DEPTH=4 pushes occur, then imem_pc holds at 4.
  - Raising out_ready drains PCs 0..3 in order.
  - Fetching resumes without gaps.
- Redirect to 50 while the FIFO holds 3 entries and out_ready=1:
  - Next cycle out_valid=0 and imem_pc=50.
  - The following cycle gives out_pc=50 and out_instr=150.
  - No old entries appear.
- halt pulsed for 3 cycles mid-stream: no PC advance during the halt, the FIFO drains, and the PC sequence continues contiguously afterwards.
- INS=8 with a free-running sink:
  - PCs 0..7 are delivered, then the block reaches DONE and out_valid falls.
  - imem_pc stays at 8 and no push occurs.
  - Redirect to 2 restarts delivery at PC 2.
- rst asserted with a full FIFO mid-redirect: after the edge, out_valid=0, imem_pc=RESET_PC and state=FETCH.
